// File: rtl/alu_pkg.sv
// Shared encodings for alu_seq: opcodes, condition codes, shift codes, flag indices, FSM state.
// The MUL state exists only when ALU_MUL_EN is defined.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_MOVI = 4'b0110;
    localparam logic [3:0] OP_MOV  = 4'b0111;
    localparam logic [3:0] OP_CMP  = 4'b1000;
    localparam logic [3:0] OP_LDR  = 4'b1101;
    localparam logic [3:0] OP_STR  = 4'b1110;

    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_MI = 4'b0100;
    localparam logic [3:0] CC_PL = 4'b0101;
    localparam logic [3:0] CC_VS = 4'b0110;
    localparam logic [3:0] CC_VC = 4'b0111;
    localparam logic [3:0] CC_HI = 4'b1000;
    localparam logic [3:0] CC_LS = 4'b1001;
    localparam logic [3:0] CC_GE = 4'b1010;
    localparam logic [3:0] CC_LT = 4'b1011;
    localparam logic [3:0] CC_GT = 4'b1100;
    localparam logic [3:0] CC_LE = 4'b1101;

    localparam logic [2:0] SR_LSR = 3'b001;
    localparam logic [2:0] SR_LSL = 3'b010;
    localparam logic [2:0] SR_ROR = 3'b011;
    localparam logic [2:0] SR_ASR = 3'b100;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

`ifdef ALU_MUL_EN
    typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;
`else
    typedef enum logic {ST_IDLE = 1'b0} state_t;
`endif

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, ok;
        n  = f[FLAG_N];
        z  = f[FLAG_Z];
        cy = f[FLAG_C];
        v  = f[FLAG_V];
        case (c)
            CC_EQ:   ok = z;
            CC_NE:   ok = !z;
            CC_CS:   ok = cy;
            CC_CC:   ok = !cy;
            CC_MI:   ok = n;
            CC_PL:   ok = !n;
            CC_VS:   ok = v;
            CC_VC:   ok = !v;
            CC_HI:   ok = cy && !z;
            CC_LS:   ok = !cy || z;
            CC_GE:   ok = (n == v);
            CC_LT:   ok = (n != v);
            CC_GT:   ok = !z && (n == v);
            CC_LE:   ok = z || (n != v);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier: one multiplier bit per cycle, WIDTH cycles, low WIDTH product bits.
// done is combinational on the final step so the caller can load p on that same edge.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] p
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] step_sum;

    // Low bits of the two's-complement product equal the low bits of the unsigned product.
    assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done     = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign p        = step_sum;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = step_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (done) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with flag register, condition evaluation and shifted operand 2.
// Define ALU_MUL_EN to build the iterative multiplier and the MUL state; otherwise MUL is illegal.
module alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [3:0]       cond,
    input  logic             s,
    input  logic [2:0]       sr_cont,
    input  logic [SHW-1:0]   sr_bit,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [15:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             wb_en,
    output logic [3:0]       flags
);
    localparam int MSB = WIDTH - 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             wb_en_q, wb_en_d, out_valid_q, out_valid_d;
    logic [3:0]       flags_q, flags_d;

    logic             accept, pass, legal, alu_wb, c_new, v_new, add_v, sub_v;
    logic [SHW-1:0]   ror_lsh;
    logic [WIDTH-1:0] op2, alu_res, nz_src;
    logic [WIDTH:0]   add_full, sub_full;

    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign pass      = cond_pass(cond, flags_q);
    assign out       = out_q;
    assign wb_en     = wb_en_q;
    assign out_valid = out_valid_q;
    assign flags     = flags_q;

    // Left shift of (-sr_bit mod WIDTH) completes the rotate; a zero amount leaves in2 intact.
    assign ror_lsh = (~sr_bit) + SHW'(1);

    always_comb begin
        case (sr_cont)
            SR_LSR:  op2 = in2 >> sr_bit;
            SR_LSL:  op2 = in2 << sr_bit;
            SR_ROR:  op2 = (in2 >> sr_bit) | (in2 << ror_lsh);
            SR_ASR:  op2 = $signed(in2) >>> sr_bit;
            default: op2 = in2;
        endcase
    end

    assign add_full = {1'b0, in1} + {1'b0, op2};
    assign sub_full = {1'b0, in1} - {1'b0, op2};
    assign add_v    = (in1[MSB] == op2[MSB]) && (add_full[MSB] != in1[MSB]);
    assign sub_v    = (in1[MSB] != op2[MSB]) && (sub_full[MSB] != in1[MSB]);

    always_comb begin
        alu_res = '0;
        alu_wb  = 1'b1;
        legal   = 1'b1;
        c_new   = flags_q[FLAG_C];
        v_new   = flags_q[FLAG_V];
        case (opcode)
            OP_ADD:  begin alu_res = add_full[MSB:0]; c_new = add_full[WIDTH];  v_new = add_v; end
            OP_SUB:  begin alu_res = sub_full[MSB:0]; c_new = !sub_full[WIDTH]; v_new = sub_v; end
            OP_CMP:  begin alu_wb  = 1'b0;            c_new = !sub_full[WIDTH]; v_new = sub_v; end
            OP_OR:   alu_res = in1 | op2;
            OP_AND:  alu_res = in1 & op2;
            OP_XOR:  alu_res = in1 ^ op2;
            OP_MOVI: alu_res = WIDTH'(imm);
            OP_MOV, OP_LDR, OP_STR: alu_res = in1;
            default: begin legal = 1'b0; alu_wb = 1'b0; end
        endcase
        // CMP reports N/Z of the subtraction even though out is forced to zero.
        nz_src = (opcode == OP_CMP) ? sub_full[MSB:0] : alu_res;
    end

`ifdef ALU_MUL_EN
    logic             mul_start, mul_done, mul_s_q, mul_s_d;
    logic [WIDTH-1:0] mul_p;

    assign mul_start = accept && pass && (opcode == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (in1),
        .b     (op2),
        .done  (mul_done),
        .p     (mul_p)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mul_s_q <= 1'b0;
        else     mul_s_q <= mul_s_d;
    end
`endif

    always_comb begin
        state_d = state_q;
`ifdef ALU_MUL_EN
        case (state_q)
            ST_IDLE: if (mul_start) state_d = ST_MUL;
            ST_MUL:  if (mul_done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
`endif
    end

    always_comb begin
        out_d       = out_q;
        wb_en_d     = wb_en_q;
        out_valid_d = out_valid_q && !out_ready;
        flags_d     = flags_q;
`ifdef ALU_MUL_EN
        mul_s_d     = mul_s_q;
`endif
        if (accept) begin
            if (!pass) begin
                out_d       = '0;
                wb_en_d     = 1'b0;
                out_valid_d = 1'b1;
`ifdef ALU_MUL_EN
            end else if (opcode == OP_MUL) begin
                mul_s_d = s;
`endif
            end else begin
                out_d       = alu_res;
                wb_en_d     = alu_wb;
                out_valid_d = 1'b1;
                if (legal && (s || opcode == OP_CMP))
                    flags_d = {nz_src[MSB], (nz_src == '0), c_new, v_new};
            end
        end
`ifdef ALU_MUL_EN
        if (state_q == ST_MUL && mul_done) begin
            out_d       = mul_p;
            wb_en_d     = 1'b1;
            out_valid_d = 1'b1;
            if (mul_s_q) begin
                flags_d[FLAG_N] = mul_p[MSB];
                flags_d[FLAG_Z] = (mul_p == '0);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            wb_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            flags_q     <= 4'b0000;
        end else begin
            out_q       <= out_d;
            wb_en_q     <= wb_en_d;
            out_valid_q <= out_valid_d;
            flags_q     <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32): directed plan scenarios plus randomized ops with backpressure.
`timescale 1ns/1ps
module tb_alu_seq;
    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, s, out_valid, out_ready, wb_en;
    logic [3:0]  opcode, cond, flags;
    logic [2:0]  sr_cont;
    logic [4:0]  sr_bit;
    logic [31:0] in1, in2, out;
    logic [15:0] imm;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .cond(cond), .s(s), .sr_cont(sr_cont), .sr_bit(sr_bit),
        .in1(in1), .in2(in2), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .wb_en(wb_en), .flags(flags)
    );

    typedef struct {
        logic [31:0] out;
        logic        wb;
        logic [3:0]  flags;
        int          acc;
        int          lat;
    } exp_t;

    exp_t       q[$];
    int         errors = 0, checks = 0, cyc = 0, first_seen = -1, txn = 0;
    logic [3:0] m_flags = 4'b0000;
    bit         rand_rdy = 1'b0;
    logic       rdy_force = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Reference model: condition/flag rules evaluated with wide integer arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [3:0] cnd, input logic sb,
                                   input logic [2:0] sc, input logic [4:0] sa,
                                   input logic [31:0] a, input logic [31:0] b, input logic [15:0] im);
        exp_t e;
        logic n, z, c, v, pass, legal;
        logic [31:0] o2, r, nz;
        longint unsigned ua, ub;
        longint sa_l, sb_l, sr;
        n = m_flags[3]; z = m_flags[2]; c = m_flags[1]; v = m_flags[0];
        case (cnd)
            4'd0: pass = z;          4'd1: pass = !z;
            4'd2: pass = c;          4'd3: pass = !c;
            4'd4: pass = n;          4'd5: pass = !n;
            4'd6: pass = v;          4'd7: pass = !v;
            4'd8: pass = c && !z;    4'd9: pass = !c || z;
            4'd10: pass = (n == v);  4'd11: pass = (n != v);
            4'd12: pass = !z && (n == v);
            4'd13: pass = z || (n != v);
            default: pass = 1'b1;
        endcase
        o2 = b;
        for (int i = 0; i < int'(sa); i++) begin
            case (sc)
                3'd1: o2 = {1'b0, o2[31:1]};
                3'd2: o2 = {o2[30:0], 1'b0};
                3'd3: o2 = {o2[0], o2[31:1]};
                3'd4: o2 = {o2[31], o2[31:1]};
                default: ;
            endcase
        end
        ua = longint'(a); ub = longint'(o2);
        sa_l = longint'($signed(a)); sb_l = longint'($signed(o2));
        legal = 1'b1; r = 32'd0;
        case (op)
            4'd0: begin r = a + o2; c = (ua + ub) > 64'hFFFF_FFFF;
                        sr = sa_l + sb_l; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
            4'd1, 4'd8: begin r = a - o2; c = (ua >= ub);
                        sr = sa_l - sb_l; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
            4'd3: r = a | o2;
            4'd4: r = a & o2;
            4'd5: r = a ^ o2;
            4'd6: r = {16'd0, im};
            4'd7, 4'd13, 4'd14: r = a;
`ifdef ALU_MUL_EN
            4'd2: begin sr = sa_l * sb_l; r = sr[31:0]; end
`endif
            default: legal = 1'b0;
        endcase
        nz = r;
        e.lat = 1;
        if (!pass || !legal) begin
            e.out = 32'd0; e.wb = 1'b0;
        end else begin
            if (sb || op == 4'd8) m_flags = {nz[31], nz == 32'd0, c, v};
            e.out = (op == 4'd8) ? 32'd0 : r;
            e.wb  = (op != 4'd8);
`ifdef ALU_MUL_EN
            if (op == 4'd2) e.lat = 33;
`endif
        end
        e.flags = m_flags;
        e.acc = 0;
        return e;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [3:0] cnd, input logic sb,
                         input logic [2:0] sc, input logic [4:0] sa,
                         input logic [31:0] a, input logic [31:0] b, input logic [15:0] im);
        exp_t e;
        int   n = 0;
        opcode = op; cond = cnd; s = sb; sr_cont = sc; sr_bit = sa;
        in1 = a; in2 = b; imm = im; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end else begin
            e = model(op, cnd, sb, sc, sa, a, b, im);
            e.acc = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: pops and compares one expected entry per output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (first_seen < 0) first_seen = cyc;
            if (out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_result: out=%h wb_en=%b with nothing expected", out, wb_en);
                end else begin
                    e = q.pop_front();
                    txn++;
                    $display("txn %0d: out=%h wb_en=%b flags=%b (exp %h %b %b)",
                             txn, out, wb_en, flags, e.out, e.wb, e.flags);
                    if (out !== e.out || wb_en !== e.wb || flags !== e.flags) begin
                        errors++;
                        $display("FAIL result_%0d: got out=%h wb_en=%b flags=%b, required out=%h wb_en=%b flags=%b",
                                 txn, out, wb_en, flags, e.out, e.wb, e.flags);
                    end
                    checks++;
                    if (first_seen - e.acc + 1 != e.lat) begin
                        errors++;
                        $display("FAIL latency_%0d: got %0d edges, required %0d",
                                 txn, first_seen - e.acc + 1, e.lat);
                    end
                end
                first_seen = -1;
            end
        end
    end

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int hi, n;
        rst = 1'b1; in_valid = 1'b0; opcode = '0; cond = '0; s = 1'b0; sr_cont = '0;
        sr_bit = '0; in1 = '0; in2 = '0; imm = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out", out, 32'd0);
        chk("reset_wb_en", {31'd0, wb_en}, 32'd0);
        chk("reset_flags", {28'd0, flags}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        issue(4'd0, 4'd14, 1'b1, 3'd0, 5'd0, 32'h7FFF_FFFF, 32'h1, 16'h0);
        @(negedge clk);
        chk("add_ovf_valid", {31'd0, out_valid}, 32'd1);
        chk("add_ovf_out", out, 32'h8000_0000);
        chk("add_ovf_flags", {28'd0, flags}, 32'h9);
        @(posedge clk); #1;

        issue(4'd8, 4'd15, 1'b0, 3'd0, 5'd0, 32'd5, 32'd5, 16'h0);
        @(negedge clk);
        chk("cmp_wb_en", {31'd0, wb_en}, 32'd0);
        chk("cmp_flags", {28'd0, flags}, 32'h6);
        @(posedge clk); #1;
        issue(4'd0, 4'd0, 1'b0, 3'd0, 5'd0, 32'd1, 32'd2, 16'h0);
        @(negedge clk);
        chk("add_eq_out", out, 32'd3);
        @(posedge clk); #1;
        issue(4'd0, 4'd1, 1'b0, 3'd0, 5'd0, 32'd1, 32'd2, 16'h0);
        @(negedge clk);
        chk("add_ne_out", out, 32'd0);
        chk("add_ne_wb_en", {31'd0, wb_en}, 32'd0);
        chk("add_ne_flags", {28'd0, flags}, 32'h6);
        @(posedge clk); #1;

        issue(4'd2, 4'd14, 1'b1, 3'd0, 5'd0, 32'hFFFF_FFFF, 32'h3, 16'h0);
`ifdef ALU_MUL_EN
        hi = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (in_ready || out_valid) hi++;
        end
        chk("mul_busy_ready_high", hi, 0);
        @(negedge clk);
        chk("mul_out", out, 32'hFFFF_FFFD);
        chk("mul_flags", {28'd0, flags}, 32'hA);
`else
        @(negedge clk);
        chk("mul_illegal_out", out, 32'd0);
        chk("mul_illegal_wb_en", {31'd0, wb_en}, 32'd0);
        chk("mul_illegal_flags", {28'd0, flags}, 32'h6);
`endif
        @(posedge clk); #1;

        issue(4'd3, 4'd14, 1'b0, 3'd3, 5'd1, 32'd0, 32'h0000_0001, 16'h0);
        @(negedge clk); chk("ror1", out, 32'h8000_0000); @(posedge clk); #1;
        issue(4'd3, 4'd14, 1'b0, 3'd4, 5'd4, 32'd0, 32'h8000_0000, 16'h0);
        @(negedge clk); chk("asr4", out, 32'hF800_0000); @(posedge clk); #1;
        issue(4'd3, 4'd14, 1'b0, 3'd1, 5'd4, 32'd0, 32'h8000_0000, 16'h0);
        @(negedge clk); chk("lsr4", out, 32'h0800_0000); @(posedge clk); #1;

        rdy_force = 1'b0;
        issue(4'd5, 4'd14, 1'b0, 3'd0, 5'd0, 32'h1234, 32'h00FF, 16'h0);
        opcode = 4'd0; cond = 4'd14; s = 1'b0; sr_cont = 3'd0; sr_bit = 5'd0;
        in1 = 32'd10; in2 = 32'd20; in_valid = 1'b1;
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_ready || !out_valid || out !== 32'h12CB || !wb_en) hi++;
        end
        chk("backpressure_hold", hi, 0);
        rdy_force = 1'b1;
        issue(4'd0, 4'd14, 1'b0, 3'd0, 5'd0, 32'd10, 32'd20, 16'h0);
        @(negedge clk);
        chk("drain_accept_out", out, 32'd30);
        @(posedge clk); #1;

        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), rnd_val(), rnd_val(),
                  16'($urandom()));
        end
        rand_rdy = 1'b0;
        rdy_force = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 500) begin @(posedge clk); n++; end
        chk("random_drain_left", q.size(), 0);
        @(posedge clk); #1;

        issue(4'd2, 4'd14, 1'b1, 3'd0, 5'd0, 32'h1234_5678, 32'h9ABC_DEF1, 16'h0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        q.delete();
        first_seen = -1;
        m_flags = 4'b0000;
        @(negedge clk);
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_flags", {28'd0, flags}, 32'd0);
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        issue(4'd0, 4'd14, 1'b1, 3'd0, 5'd0, 32'd1, 32'd2, 16'h0);
        @(negedge clk);
        chk("post_rst_add_out", out, 32'd3);
        n = 0;
        while (q.size() != 0 && n < 100) begin @(posedge clk); n++; end
        chk("final_drain_left", q.size(), 0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
